rover_nav_controller: RTL and testbench

- Parametrised obstacle-avoidance controller for the rover: N-channel active-low IR sensor inputs (front and back banks), per-channel synchronise and debounce, navigation FSM, PWM speed generation.
- Drives the H-bridge direction pins and the two motor-enable PWM pins.
- Sits between the Pmod sensor headers and the motor-driver header, below the board top level.

---
 rtl/rover_pkg.sv | 30 +++
 rtl/ir_debounce.sv | 50 +++++
 rtl/rover_nav_controller.sv | 158 +++++++++++++++
 tb/tb_rover_nav_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rover_pkg.sv
// Shared types and constants for the rover navigation controller: FSM state
// encoding, H-bridge direction codes and the counter-width helper.
package rover_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FORWARD = 3'd1,
    ST_BACKOFF = 3'd2,
    ST_PIVOT_L = 3'd3,
    ST_PIVOT_R = 3'd4,
    ST_HALT    = 3'd5
  } state_e;

  // {right_rev, right_fwd, left_rev, left_fwd}
  localparam logic [3:0] DIR_STOP  = 4'b0000;
  localparam logic [3:0] DIR_FWD   = 4'b0101;
  localparam logic [3:0] DIR_REV   = 4'b1010;
  localparam logic [3:0] DIR_PIV_L = 4'b0110;
  localparam logic [3:0] DIR_PIV_R = 4'b1001;

  // Bits needed to hold 0..max_val, i.e. clog2(max_val+1), at least 1.
  function automatic int timer_width(input int max_val);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++)
      if ((max_val >>> i) != 0) w = i + 1;
    return w;
  endfunction

endpackage

// File: rtl/ir_debounce.sv
// Per-bit 2-FF synchroniser plus stability counter for a bank of active-low
// IR sensors; the debounced bit follows only after DEBOUNCE_CYCLES of disagreement.
module ir_debounce
  import rover_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_n,
  output logic [WIDTH-1:0] db_n
);

  localparam int             CW       = timer_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] db_q, db_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      db_d[i]  = db_q[i];
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) db_d[i] = sync2_q[i];
        else                      cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      db_q    <= '1;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw_n;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign db_n = db_q;

endmodule

// File: rtl/rover_nav_controller.sv
// Obstacle-avoidance controller: debounced IR banks, navigation FSM, PWM drive.
// Define ROVER_DEAD_TIME_EN to insert a DEAD_CYCLES brake gap between direction codes.
module rover_nav_controller
  import rover_pkg::*;
#(
  parameter int N_FRONT         = 4,
  parameter int N_BACK          = 4,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int REVERSE_CYCLES  = 50000000,
  parameter int PIVOT_CYCLES    = 40000000,
  parameter int DEAD_CYCLES     = 1000,
  parameter int PWM_BITS        = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] speed_cruise,
  input  logic [PWM_BITS-1:0] speed_turn,
  input  logic [N_FRONT-1:0]  sens_front_n,
  input  logic [N_BACK-1:0]   sens_back_n,
  output logic [1:0]          motor_pwm,
  output logic [3:0]          direction,
  output logic [2:0]          state_o,
  output logic                obst_front,
  output logic                obst_back
);

  localparam int T_MAX0 = (REVERSE_CYCLES > PIVOT_CYCLES) ? REVERSE_CYCLES : PIVOT_CYCLES;
  localparam int T_MAX  = (T_MAX0 > DEAD_CYCLES) ? T_MAX0 : DEAD_CYCLES;
  localparam int TW     = timer_width(T_MAX);
  localparam logic [TW-1:0] REV_LAST = TW'(REVERSE_CYCLES - 1);
  localparam logic [TW-1:0] PIV_LAST = TW'(PIVOT_CYCLES - 1);

  logic [N_FRONT-1:0] front_db_n;
  logic [N_BACK-1:0]  back_db_n;
  logic               right_hit, left_hit;

  ir_debounce #(.WIDTH(N_FRONT), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_front (
    .clock(clock), .reset(reset), .raw_n(sens_front_n), .db_n(front_db_n)
  );
  ir_debounce #(.WIDTH(N_BACK), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_back (
    .clock(clock), .reset(reset), .raw_n(sens_back_n), .db_n(back_db_n)
  );

  assign obst_front = ~&front_db_n;
  assign obst_back  = ~&back_db_n;
  assign right_hit  = ~&front_db_n[N_FRONT/2-1:0];
  assign left_hit   = ~&front_db_n[N_FRONT-1:N_FRONT/2];

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pivot_l_q, pivot_l_d;

  always_comb begin
    state_d   = state_q;
    pivot_l_d = pivot_l_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_FORWARD;
        ST_FORWARD: begin
          if (obst_front && obst_back) state_d = ST_HALT;
          else if (obst_front) begin
            state_d   = ST_BACKOFF;
            pivot_l_d = right_hit && !left_hit;
          end
        end
        ST_BACKOFF: if (obst_back || timer_q == REV_LAST)
                      state_d = pivot_l_q ? ST_PIVOT_L : ST_PIVOT_R;
        ST_PIVOT_L,
        ST_PIVOT_R: if (timer_q == PIV_LAST) state_d = ST_FORWARD;
        ST_HALT:    if (!obst_front) state_d = ST_FORWARD;
        default:    state_d = ST_IDLE;
      endcase
    end
    // Timer restarts on every state entry and saturates instead of wrapping.
    if (!enable || state_d != state_q) timer_d = '0;
    else if (timer_q != '1)            timer_d = timer_q + TW'(1);
    else                               timer_d = timer_q;
  end

  logic [3:0]          dir_tgt, dir_q, dir_d;
  logic [PWM_BITS-1:0] duty_sel, duty_q, duty_d, cnt_q, cnt_d;
  logic [1:0]          pwm_q, pwm_d;
  logic                pwm_on, hold;

  always_comb begin
    dir_tgt  = DIR_STOP;
    duty_sel = '0;
    case (state_q)
      ST_FORWARD: begin dir_tgt = DIR_FWD;   duty_sel = speed_cruise; end
      ST_BACKOFF: begin dir_tgt = DIR_REV;   duty_sel = speed_cruise; end
      ST_PIVOT_L: begin dir_tgt = DIR_PIV_L; duty_sel = speed_turn;   end
      ST_PIVOT_R: begin dir_tgt = DIR_PIV_R; duty_sel = speed_turn;   end
      default:    ;
    endcase
    // New duty is loaded only as the counter wraps, so no partial pulses appear.
    cnt_d  = cnt_q + PWM_BITS'(1);
    duty_d = (cnt_q == '1) ? duty_sel : duty_q;
    pwm_on = (duty_d == '1) || (cnt_d < duty_d);
  end

`ifdef ROVER_DEAD_TIME_EN
  localparam int GW = timer_width(DEAD_CYCLES);
  logic [GW-1:0] gap_q, gap_d;
  logic [3:0]    tgt_q, tgt_d;

  always_comb begin
    tgt_d = dir_tgt;
    gap_d = (gap_q != '0) ? gap_q - GW'(1) : '0;
    // Any move to a new non-zero code out of a driven code or an open gap restarts the gap.
    if (dir_tgt != tgt_q && dir_tgt != DIR_STOP && (tgt_q != DIR_STOP || gap_q != '0))
      gap_d = GW'(DEAD_CYCLES);
    hold = (gap_d != '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gap_q <= '0;
      tgt_q <= DIR_STOP;
    end else begin
      gap_q <= gap_d;
      tgt_q <= tgt_d;
    end
  end
`else
  assign hold = 1'b0;
`endif

  assign dir_d = hold ? DIR_STOP : dir_tgt;
  assign pwm_d = hold ? 2'b00 : {2{pwm_on}};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      pivot_l_q <= 1'b0;
      dir_q     <= DIR_STOP;
      duty_q    <= '0;
      cnt_q     <= '0;
      pwm_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pivot_l_q <= pivot_l_d;
      dir_q     <= dir_d;
      duty_q    <= duty_d;
      cnt_q     <= cnt_d;
      pwm_q     <= pwm_d;
    end
  end

  assign state_o   = state_q;
  assign direction = dir_q;
  assign motor_pwm = pwm_q;

endmodule

// File: tb/tb_rover_nav_controller.sv
// Directed bench for rover_nav_controller: state/direction vector table plus
// PWM, halt, pivot-duty, reset and (with ROVER_DEAD_TIME_EN) brake-gap sequences.
module tb_rover_nav_controller;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [3:0] speed_cruise, speed_turn;
  logic [3:0] sens_front_n, sens_back_n;
  logic [1:0] motor_pwm;
  logic [3:0] direction;
  logic [2:0] state_o;
  logic       obst_front, obst_back;

  int ncmp = 0;
  int nerr = 0;

`ifdef ROVER_DEAD_TIME_EN
  localparam bit DT = 1'b1;
`else
  localparam bit DT = 1'b0;
`endif

  rover_nav_controller #(
    .N_FRONT(4), .N_BACK(4), .DEBOUNCE_CYCLES(4), .REVERSE_CYCLES(20),
    .PIVOT_CYCLES(30), .DEAD_CYCLES(3), .PWM_BITS(4)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .speed_cruise(speed_cruise), .speed_turn(speed_turn),
    .sens_front_n(sens_front_n), .sens_back_n(sens_back_n),
    .motor_pwm(motor_pwm), .direction(direction), .state_o(state_o),
    .obst_front(obst_front), .obst_back(obst_back)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       en;
    logic [3:0] front;
    logic [3:0] back;
    int         hold;
    logic [2:0] st;
    logic [3:0] dir;
    logic       of;
    logic       ob;
    logic       trans;  // direction sampled right after a code change
  } vec_t;

  vec_t vt [27];

  logic [3:0] duties [4] = '{4'd8, 4'd0, 4'hF, 4'd3};
  int         dexp   [4] = '{8, 0, 16, 3};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string name);
    int n;
    n = 0;
    while (state_o !== st && n < budget) begin
      @(negedge clock);
      n++;
    end
    ncmp++;
    if (state_o !== st) begin
      nerr++;
      $display("FAIL %s: state %0d after %0d cycles, expected %0d", name, state_o, n, st);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int highs, split;

    //   en  front  back  hold st    dir      of ob trans
    vt[0]  = '{1'b1, 4'hF, 4'hF,  2, 3'd1, 4'b0101, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 4'hE, 4'hF,  5, 3'd1, 4'b0101, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 4'hE, 4'hF,  1, 3'd1, 4'b0101, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 4'hE, 4'hF,  1, 3'd2, 4'b0101, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 4'hE, 4'hF,  1, 3'd2, 4'b1010, 1'b1, 1'b0, 1'b1};
    vt[5]  = '{1'b1, 4'hF, 4'hF, 18, 3'd2, 4'b1010, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 4'hF, 4'hF,  1, 3'd3, 4'b1010, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 4'hF, 4'hF,  1, 3'd3, 4'b0110, 1'b0, 1'b0, 1'b1};
    vt[8]  = '{1'b1, 4'hF, 4'hF, 28, 3'd3, 4'b0110, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 4'hF, 4'hF,  1, 3'd1, 4'b0110, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b1, 4'hF, 4'hF,  1, 3'd1, 4'b0101, 1'b0, 1'b0, 1'b1};
    vt[11] = '{1'b1, 4'h7, 4'hF,  3, 3'd1, 4'b0101, 1'b0, 1'b0, 1'b0};
    vt[12] = '{1'b1, 4'hF, 4'hF,  8, 3'd1, 4'b0101, 1'b0, 1'b0, 1'b0};
    vt[13] = '{1'b1, 4'h7, 4'hF,  7, 3'd2, 4'b0101, 1'b1, 1'b0, 1'b0};
    vt[14] = '{1'b1, 4'hF, 4'hF, 20, 3'd4, 4'b1010, 1'b0, 1'b0, 1'b0};
    vt[15] = '{1'b1, 4'hF, 4'hF,  1, 3'd4, 4'b1001, 1'b0, 1'b0, 1'b1};
    vt[16] = '{1'b1, 4'hF, 4'hF, 30, 3'd1, 4'b0101, 1'b0, 1'b0, 1'b1};
    vt[17] = '{1'b1, 4'h0, 4'h0,  7, 3'd5, 4'b0101, 1'b1, 1'b1, 1'b0};
    vt[18] = '{1'b1, 4'h0, 4'h0,  1, 3'd5, 4'b0000, 1'b1, 1'b1, 1'b0};
    vt[19] = '{1'b1, 4'hF, 4'h0,  6, 3'd5, 4'b0000, 1'b0, 1'b1, 1'b0};
    vt[20] = '{1'b1, 4'hF, 4'h0,  2, 3'd1, 4'b0101, 1'b0, 1'b1, 1'b0};
    vt[21] = '{1'b1, 4'hF, 4'hF,  8, 3'd1, 4'b0101, 1'b0, 1'b0, 1'b0};
    vt[22] = '{1'b1, 4'hE, 4'hF,  7, 3'd2, 4'b0101, 1'b1, 1'b0, 1'b0};
    vt[23] = '{1'b1, 4'hE, 4'hF,  4, 3'd2, 4'b1010, 1'b1, 1'b0, 1'b0};
    vt[24] = '{1'b1, 4'hF, 4'hE,  7, 3'd3, 4'b1010, 1'b0, 1'b1, 1'b0};
    vt[25] = '{1'b0, 4'hF, 4'hE,  1, 3'd0, 4'b0110, 1'b0, 1'b1, 1'b1};
    vt[26] = '{1'b0, 4'hF, 4'hE,  1, 3'd0, 4'b0000, 1'b0, 1'b1, 1'b0};

    reset        = 1'b1;
    enable       = 1'b0;
    speed_cruise = 4'd8;
    speed_turn   = 4'hF;
    sens_front_n = 4'hF;
    sens_back_n  = 4'hF;
    tick(2);
    chk("reset_state", state_o, 3'd0);
    chk("reset_dir", direction, 4'b0000);
    chk("reset_pwm", motor_pwm, 2'b00);
    chk("reset_obst", {obst_front, obst_back}, 2'b00);
    reset = 1'b0;

    for (int i = 0; i < 27; i++) begin
      enable       = vt[i].en;
      sens_front_n = vt[i].front;
      sens_back_n  = vt[i].back;
      tick(vt[i].hold);
      chk($sformatf("vec%0d_state", i), state_o, vt[i].st);
      chk($sformatf("vec%0d_obst", i), {obst_front, obst_back}, {vt[i].of, vt[i].ob});
      if (!(DT && vt[i].trans))
        chk($sformatf("vec%0d_dir", i), direction, vt[i].dir);
    end

    enable      = 1'b1;
    sens_back_n = 4'hF;
    wait_state(3'd1, 5, "resume_forward");

    // PWM duty patterns in FORWARD (16-cycle period)
    split = 0;
    for (int k = 0; k < 4; k++) begin
      speed_cruise = duties[k];
      tick(40);
      highs = 0;
      for (int c = 0; c < 16; c++) begin
        @(negedge clock);
        if (motor_pwm[0]) highs++;
        if (motor_pwm[0] !== motor_pwm[1]) split++;
      end
      chk($sformatf("pwm_duty%0h_highs", duties[k]), highs, dexp[k]);
    end
    chk("pwm_bits_equal", split, 0);
    speed_cruise = 4'd8;

    // Full-duty pivot with speed_turn = F
    sens_front_n = 4'hE;
    wait_state(3'd2, 20, "pivot_duty_backoff");
    sens_front_n = 4'hF;
    wait_state(3'd3, 40, "pivot_duty_pivot_l");
    tick(17);
    highs = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (motor_pwm == 2'b11) highs++;
    end
    chk("pivot_full_duty", highs, 10);
    wait_state(3'd1, 40, "pivot_duty_forward");

    // HALT keeps the motors off
    sens_front_n = 4'h0;
    sens_back_n  = 4'h0;
    wait_state(3'd5, 20, "halt_enter");
    tick(17);
    highs = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      if (motor_pwm != 2'b00) highs++;
    end
    chk("halt_pwm_off", highs, 0);
    chk("halt_dir", direction, 4'b0000);
    sens_front_n = 4'hF;
    wait_state(3'd1, 20, "halt_release");
    sens_back_n = 4'hF;
    tick(40);

    // Direction change out of FORWARD, then async reset one cycle into a pivot
    sens_front_n = 4'hE;
    wait_state(3'd2, 20, "gap_backoff");
`ifdef ROVER_DEAD_TIME_EN
    chk("gap_entry_dir", direction, 4'b0101);
    for (int g = 0; g < 3; g++) begin
      tick(1);
      chk($sformatf("gap%0d_dir", g), direction, 4'b0000);
      chk($sformatf("gap%0d_pwm", g), motor_pwm, 2'b00);
    end
    tick(1);
    chk("gap_done_dir", direction, 4'b1010);
`else
    tick(1);
    chk("nogap_dir", direction, 4'b1010);
`endif
    wait_state(3'd3, 40, "reset_pivot_l");
    tick(1);
    chk("pivot_next_dir", direction, DT ? 4'b0000 : 4'b0110);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_state", state_o, 3'd0);
    chk("async_reset_dir", direction, 4'b0000);
    chk("async_reset_pwm", motor_pwm, 2'b00);
    chk("async_reset_obst", obst_front, 1'b0);
    enable = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    tick(5);
    chk("debounce_restart_early", obst_front, 1'b0);
    tick(1);
    chk("debounce_restart_done", obst_front, 1'b1);
    chk("idle_after_reset", state_o, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
